// File: rtl/lsu_mem_if_if.sv
// Bundle of the LSU pipeline-side and memory-side signals of lsu_mem_if.
// master = the LSU itself, slave = the pipeline/memory environment driving it.
interface lsu_mem_if_if;
    logic        i_memRead;
    logic        i_memWrite;
    logic [1:0]  i_memSize;
    logic        i_isLoadSigned;
    logic [31:0] i_addr;
    logic [31:0] i_writeData;
    logic        o_req;
    logic        o_we;
    logic [31:0] o_addr;
    logic [3:0]  o_be;
    logic [31:0] o_wdata;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        o_stall;
    logic [31:0] o_readData;
    logic        o_misaligned;
    logic        o_accessFault;

    modport master (
        input  i_memRead, i_memWrite, i_memSize, i_isLoadSigned, i_addr, i_writeData,
        input  i_ack, i_rdata,
        output o_req, o_we, o_addr, o_be, o_wdata, o_stall, o_readData,
        output o_misaligned, o_accessFault
    );

    modport slave (
        output i_memRead, i_memWrite, i_memSize, i_isLoadSigned, i_addr, i_writeData,
        output i_ack, i_rdata,
        input  o_req, o_we, o_addr, o_be, o_wdata, o_stall, o_readData,
        input  o_misaligned, o_accessFault
    );
endinterface

// File: rtl/lsu_mem_if.sv
// MEM-stage load/store unit: latches one aligned access, runs a req/ack memory
// handshake with a timeout, and returns the lane-selected, extended load result.
module lsu_mem_if #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    lsu_mem_if_if.master  bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_next;
    logic        access, misaligned, start, busy, ack_take, timeout;
    logic [7:0]  cnt;
    logic [31:0] lat_addr, lat_wdata;
    logic [1:0]  lat_size;
    logic        lat_signed, lat_we;
    logic [31:0] read_data, load_ext, lane_word, wdata_sh;
    logic [3:0]  be;
    logic        fault;

    assign access = bus.i_memRead | bus.i_memWrite;

    always_comb begin
        misaligned = 1'b0;
        case (bus.i_memSize)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = bus.i_addr[0];
            2'b10:   misaligned = |bus.i_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    assign busy     = (state == BUSY);
    assign start    = (state == IDLE) & access & ~misaligned;
    assign ack_take = busy & bus.i_ack;
    // Counter holds the number of completed unacked BUSY cycles, so the
    // TIMEOUT-th unacked cycle is the one where cnt == TIMEOUT-1.
    assign timeout  = busy & ~bus.i_ack & (cnt == 8'(TIMEOUT - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (ack_take || timeout) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Halfwords are aligned, so one byte-granular shift serves every size.
    always_comb begin
        lane_word = bus.i_rdata >> {lat_addr[1:0], 3'b000};
        load_ext  = lane_word;
        case (lat_size)
            2'b00:   load_ext = {{24{lat_signed & lane_word[7]}}, lane_word[7:0]};
            2'b01:   load_ext = {{16{lat_signed & lane_word[15]}}, lane_word[15:0]};
            default: load_ext = lane_word;
        endcase
    end

    always_comb begin
        be       = '0;
        wdata_sh = '0;
        case (lat_size)
            2'b00: begin
                be       = 4'b0001 << lat_addr[1:0];
                wdata_sh = {24'd0, lat_wdata[7:0]} << {lat_addr[1:0], 3'b000};
            end
            2'b01: begin
                be       = 4'b0011 << {lat_addr[1], 1'b0};
                wdata_sh = {16'd0, lat_wdata[15:0]} << {lat_addr[1], 4'b0000};
            end
            2'b10: begin
                be       = 4'b1111;
                wdata_sh = lat_wdata;
            end
            default: begin
                be       = '0;
                wdata_sh = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_size   <= '0;
            lat_signed <= 1'b0;
            lat_we     <= 1'b0;
            read_data  <= '0;
            fault      <= 1'b0;
        end else begin
            state <= state_next;
            fault <= timeout;
            if (start) begin
                lat_addr   <= bus.i_addr;
                lat_wdata  <= bus.i_writeData;
                lat_size   <= bus.i_memSize;
                lat_signed <= bus.i_isLoadSigned;
                lat_we     <= bus.i_memWrite;
                cnt        <= '0;
            end else if (busy && !bus.i_ack) begin
                cnt <= cnt + 8'd1;
            end
            if (ack_take) begin
                read_data <= lat_we ? '0 : load_ext;
            end else if (timeout) begin
                read_data <= '0;
            end
        end
    end

    assign bus.o_req         = busy;
    assign bus.o_we          = busy & lat_we;
    assign bus.o_addr        = busy ? {lat_addr[31:2], 2'b00} : '0;
    assign bus.o_be          = busy ? be : '0;
    assign bus.o_wdata       = (busy & lat_we) ? wdata_sh : '0;
    assign bus.o_stall       = ~reset & (start | busy);
    assign bus.o_readData    = read_data;
    assign bus.o_misaligned  = access & misaligned;
    assign bus.o_accessFault = fault;
endmodule

// File: tb/tb_lsu_mem_if.sv
// Directed bench for lsu_mem_if: expected load results go through a scoreboard
// queue at issue time and are popped when the DONE cycle appears.
module tb_lsu_mem_if;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] sb_q[$];

    lsu_mem_if_if bus ();

    lsu_mem_if #(.TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.i_memRead      = 1'b0;
        bus.i_memWrite     = 1'b0;
        bus.i_memSize      = 2'b00;
        bus.i_isLoadSigned = 1'b0;
        bus.i_addr         = '0;
        bus.i_writeData    = '0;
        bus.i_ack          = 1'b0;
        bus.i_rdata        = '0;
    endtask

    // ack_at: BUSY cycle (1-based) carrying i_ack; 0 means never acknowledge.
    task automatic run_access(input string tag, input logic wr, input logic rd,
                              input logic [1:0] size, input logic sgn,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] exp_addr, input logic [3:0] exp_be,
                              input logic [31:0] exp_wd, input int ack_at,
                              input logic [31:0] rdata, input logic [31:0] exp_rd,
                              input logic exp_fault, input int exp_stall);
        int n;
        int stall_cnt;
        logic [31:0] exp_pop;
        @(negedge clk);
        bus.i_memWrite     = wr;
        bus.i_memRead      = rd;
        bus.i_memSize      = size;
        bus.i_isLoadSigned = sgn;
        bus.i_addr         = addr;
        bus.i_writeData    = wd;
        bus.i_rdata        = rdata;
        bus.i_ack          = 1'b0;
        sb_q.push_back(exp_rd);
        #1;
        check({tag, "_idle_req"}, 32'(bus.o_req), 32'd0);
        stall_cnt = int'(bus.o_stall);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            bus.i_ack = (n == ack_at);
            #1;
            if (!bus.o_req) break;
            stall_cnt += int'(bus.o_stall);
            if (n == 1) begin
                check({tag, "_addr"}, bus.o_addr, exp_addr);
                check({tag, "_be"}, 32'(bus.o_be), 32'(exp_be));
                check({tag, "_wdata"}, bus.o_wdata, exp_wd);
                check({tag, "_we"}, 32'(bus.o_we), 32'(wr));
            end
            if (n > 300) begin
                errors++;
                checks++;
                $error("FAIL %s_bound: no DONE within %0d cycles, expected completion", tag, n);
                break;
            end
        end
        bus.i_ack = 1'b0;
        check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
        check({tag, "_done_stall"}, 32'(bus.o_stall), 32'd0);
        check({tag, "_fault"}, 32'(bus.o_accessFault), 32'(exp_fault));
        if (sb_q.size() == 0) begin
            errors++;
            checks++;
            $error("FAIL %s_sb: scoreboard empty, expected one entry", tag);
        end else begin
            exp_pop = sb_q.pop_front();
            check({tag, "_rdata"}, bus.o_readData, exp_pop);
        end
        // Following IDLE cycle: a stray ack must be ignored and the result held.
        @(negedge clk);
        idle_inputs();
        bus.i_ack   = 1'b1;
        bus.i_rdata = 32'h5A5A_5A5A;
        #1;
        check({tag, "_hold"}, bus.o_readData, exp_rd);
        check({tag, "_fault_pulse"}, 32'(bus.o_accessFault), 32'd0);
        @(negedge clk);
        bus.i_ack = 1'b0;
        #1;
        check({tag, "_hold2"}, bus.o_readData, exp_rd);
    endtask

    task automatic misaligned_case(input string tag, input logic [1:0] size, input logic [31:0] addr);
        logic req_seen;
        logic stall_seen;
        @(negedge clk);
        bus.i_memRead = 1'b1;
        bus.i_memSize = size;
        bus.i_addr    = addr;
        req_seen   = 1'b0;
        stall_seen = 1'b0;
        #1;
        check({tag, "_flag"}, 32'(bus.o_misaligned), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            req_seen   |= bus.o_req;
            stall_seen |= bus.o_stall;
        end
        check({tag, "_req"}, 32'(req_seen), 32'd0);
        check({tag, "_stall"}, 32'(stall_seen), 32'd0);
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        bus.i_memRead = 1'b1;
        bus.i_memSize = 2'b10;
        bus.i_addr    = 32'h0000_1000;
        #2;
        check("rst_stall", 32'(bus.o_stall), 32'd0);
        check("rst_req", 32'(bus.o_req), 32'd0);
        check("rst_be", 32'(bus.o_be), 32'd0);
        check("rst_rdata", bus.o_readData, 32'd0);
        check("rst_fault", 32'(bus.o_accessFault), 32'd0);
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;

        run_access("byte_st", 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00AB,
                   32'h0000_1000, 4'b1000, 32'hAB00_0000, 1, 32'h0, 32'h0, 1'b0, 2);
        run_access("half_lds", 1'b0, 1'b1, 2'b01, 1'b1, 32'h0000_2002, 32'h0,
                   32'h0000_2000, 4'b1100, 32'h0, 3, 32'h8001_1234, 32'hFFFF_8001, 1'b0, 4);
        run_access("byte_ldu", 1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_2001, 32'h0,
                   32'h0000_2000, 4'b0010, 32'h0, 1, 32'h0000_F000, 32'h0000_00F0, 1'b0, 2);
        run_access("half_st", 1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h1234_ABCD,
                   32'h0000_0100, 4'b1100, 32'hABCD_0000, 2, 32'hFFFF_FFFF, 32'h0, 1'b0, 3);
        run_access("byte_lds", 1'b0, 1'b1, 2'b00, 1'b1, 32'h0000_0003, 32'h0,
                   32'h0000_0000, 4'b1000, 32'h0, 1, 32'h80FF_FFFF, 32'hFFFF_FF80, 1'b0, 2);
        run_access("half_ldu", 1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0,
                   32'h0000_2000, 4'b1100, 32'h0, 1, 32'h8001_1234, 32'h0000_8001, 1'b0, 2);
        run_access("word_st", 1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'hCAFE_F00D,
                   32'h0000_0200, 4'b1111, 32'hCAFE_F00D, 1, 32'h0, 32'h0, 1'b0, 2);

        misaligned_case("mis_word", 2'b10, 32'h0000_3002);
        misaligned_case("mis_size3", 2'b11, 32'h0000_3000);
        misaligned_case("mis_half", 2'b01, 32'h0000_3001);

        run_access("tmo", 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0400, 32'h0,
                   32'h0000_0400, 4'b1111, 32'h0, 0, 32'h1111_2222, 32'h0, 1'b1, 5);
        run_access("tmo_ack", 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0404, 32'h0,
                   32'h0000_0404, 4'b1111, 32'h0, 4, 32'h3333_4444, 32'h3333_4444, 1'b0, 5);

        // Reset during the second BUSY cycle aborts the access outright.
        @(negedge clk);
        bus.i_memRead = 1'b1;
        bus.i_memSize = 2'b10;
        bus.i_addr    = 32'h0000_5000;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("abort_pre_req", 32'(bus.o_req), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_req", 32'(bus.o_req), 32'd0);
        check("abort_stall", 32'(bus.o_stall), 32'd0);
        check("abort_addr", bus.o_addr, 32'd0);
        check("abort_rdata", bus.o_readData, 32'd0);
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("abort_no_done_req", 32'(bus.o_req), 32'd0);
        check("abort_no_done_fault", 32'(bus.o_accessFault), 32'd0);

        run_access("post_rst", 1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_4000, 32'h0,
                   32'h0000_4000, 4'b1111, 32'h0, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 3);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lsu_mem_if.md
LSU_MEM_IF -- requirements
Module: lsu_mem_if

Interface
REQ-001 The block SHALL use one clock, `clk`, and an asynchronous, active-high reset, `reset`.
REQ-002 Parameter TIMEOUT, default 255: the maximum number of BUSY cycles to wait for `i_ack`; legal range 1..255.
REQ-003 Ports, in `name  direction  width  meaning` form:
- `clk  in  1`  clock.
- `reset  in  1`  async active-high reset.
- `i_memRead  in  1`  MEM-stage load request.
- `i_memWrite  in  1`  MEM-stage store request.
- `i_memSize  in  2`  00 byte, 01 half, 10 word, 11 reserved.
- `i_isLoadSigned  in  1`  sign-extend the load result.
- `i_addr  in  32`  byte address (MEM-stage ALU result).
- `i_writeData  in  32`  store data, right-aligned.
- `o_req  out  1`  memory request.
- `o_we  out  1`  request is a write.
- `o_addr  out  32`  word-aligned address, {addr[31:2], 2'b00}.
- `o_be  out  4`  byte enables.
- `o_wdata  out  32`  lane-shifted store data.
- `i_ack  in  1`  memory completion; valid only while `o_req`=1.
- `i_rdata  in  32`  memory read word, valid with `i_ack`.
- `o_stall  out  1`  to hazard unit; freezes the PC, IF/ID, ID/EX and EX/MEM registers.
- `o_readData  out  32`  extended load result for MEM/WB.
- `o_misaligned  out  1`  combinational misaligned/illegal-size flag.
- `o_accessFault  out  1`  one-cycle pulse on timeout.

Function
REQ-004 The block SHALL implement three states, IDLE, BUSY and DONE; reset state IDLE.
REQ-005 "Access" SHALL mean (`i_memRead` | `i_memWrite`) = 1; a write SHALL take priority when both are set.
REQ-006 A misaligned access SHALL be: half with `i_addr[0]`=1; word with `i_addr[1:0]`≠0; any access with size 11.
- `o_misaligned` SHALL be `access & misaligned`, in every state.
REQ-007 IDLE behaviour:
- Aligned access: latch addr, size, signedness, write flag and store data; go to BUSY; `o_stall`=1 combinationally in that cycle.
- Misaligned access or no access: stay in IDLE, `o_stall`=0, `o_req`=0.
REQ-008 BUSY behaviour:
- `o_req`=1 and `o_stall`=1.
- `o_addr`, `o_we`, `o_be` and `o_wdata` SHALL be driven from the latched values only; they are stable for the whole BUSY period.
- On `i_ack`=1: capture `i_rdata` and go to DONE.
REQ-009 DONE behaviour:
- `o_stall`=0 and `o_req`=0.
- `o_readData` is valid this cycle.
- The same access still present on the inputs SHALL NOT retrigger.
- Next state is IDLE unconditionally.
REQ-010 Minimum latency SHALL be 2 stall cycles (IDLE, BUSY with same-cycle ack); each additional BUSY cycle SHALL add one stall cycle.
REQ-011 Byte enables:
- Byte: `o_be` = 4'b0001 << addr[1:0].
- Half: `o_be` = 4'b0011 << (2*addr[1]).
- Word: `o_be` = 4'b1111.
- Reads SHALL use the same enables.
REQ-012 `o_wdata` SHALL equal the store data shifted left by 8*addr[1:0] (byte), 16*addr[1] (half) or 0 (word); lanes outside `o_be` SHALL be zero.
REQ-013 Load result: select the addressed lane from the captured word, then sign-extend (`i_isLoadSigned`=1) or zero-extend to 32 bits.
REQ-014 For stores, `o_readData` SHALL be 0.
REQ-015 A timeout counter (8-bit) SHALL:
- clear on entry to BUSY;
- increment on each BUSY cycle without `i_ack`.
REQ-016 If the counter reaches TIMEOUT while in BUSY with `i_ack`=0:
- go to DONE with a captured word of 0;
- `o_accessFault`=1 for exactly the DONE cycle.
- An `i_ack` arriving on that same cycle SHALL win, with no fault.
REQ-017 `i_ack` SHALL be ignored in IDLE and DONE.
REQ-018 `o_readData` SHALL hold its last value in IDLE and BUSY.

Reset
REQ-019 Asserting `reset` SHALL, immediately and asynchronously:
- force state IDLE and clear the counter and all latches;
- drive `o_req`=0, `o_we`=0, `o_be`=0, `o_addr`=0, `o_wdata`=0, `o_readData`=0, `o_stall`=0, `o_accessFault`=0.
REQ-020 A reset during BUSY SHALL abort the access with no DONE cycle.
REQ-021 The first access after reset release SHALL be serviced normally.

Verification
REQ-022 Byte store: addr=0x1003, data=0x000000AB, ack in first BUSY cycle -> `o_be`=1000, `o_wdata`=0xAB000000, `o_addr`=0x1000, `o_stall` high for exactly 2 cycles.
REQ-023 Signed half load: addr=0x2002, `i_rdata`=0x8001_1234, ack after 3 BUSY cycles -> `o_readData`=0xFFFF8001 in DONE; `o_stall` high for 4 cycles.
REQ-024 Unsigned byte load: addr=0x2001, `i_rdata`=0x0000_F000 -> `o_readData`=0x000000F0.
REQ-025 Misaligned/illegal access:
- word load, addr=0x3002 -> `o_misaligned`=1, `o_req` never 1, `o_stall`=0.
- size 11 -> same response.
REQ-026 Timeout: TIMEOUT=4, no ack -> 4 BUSY cycles, then DONE with `o_accessFault`=1 and `o_readData`=0; a repeat run with ack on the 4th BUSY cycle -> no fault.
REQ-027 Reset on the 2nd BUSY cycle -> `o_req`=0 in the same cycle; state IDLE; a following word load at 0x4000 completes normally.
